duc: RTL and testbench

- Digital up-converter; transmit-side counterpart of the receive DDC.
- Accepts signed baseband I/Q at fs/16 through a valid/ready handshake.
- Interpolates each rail by 16 with a 3-stage CIC (unity DC gain after scaling).
- Mixes to fs/4 and emits one real signed IF sample per clock to the DAC path.

---
 rtl/duc_pkg.sv | 36 +++
 rtl/cic_interp.sv | 80 ++++++++
 rtl/duc.sv | 119 +++++++++++
 tb/tb_duc.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/duc_pkg.sv
// Shared definitions for the digital up-converter.
// Holds CIC constants, the mixer phase encoding and a saturate helper
// used by the CIC scale stage and the mixer negation.
package duc_pkg;

    localparam int unsigned CIC_R      = 16;
    localparam int unsigned CIC_N      = 3;
    localparam int unsigned CIC_LOG2R  = 4;
    localparam int unsigned CIC_SHIFT  = 8;
    localparam int unsigned CIC_GROWTH = 12;

    // fs/4 mixer phase: which rail (and sign) drives the IF output
    typedef enum logic [1:0] {
        MIX_I  = 2'd0,
        MIX_NQ = 2'd1,
        MIX_NI = 2'd2,
        MIX_Q  = 2'd3
    } mix_phase_e;

    // Clamp a signed value to the range of a w-bit two's-complement number
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/cic_interp.sv
// Three-stage interpolating CIC (R=16, M=1) for one baseband rail.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   in_strobe  - one-cycle pulse: din holds a new low-rate sample
//   phase0     - one-cycle pulse: upsample slot, comb output enters integrator 1
//   din        - signed low-rate sample
//   dout       - signed high-rate output, scaled by 1/256 and saturated
module cic_interp
    import duc_pkg::*;
#(
    parameter int unsigned width = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_strobe,
    input  logic                    phase0,
    input  logic signed [width-1:0] din,
    output logic signed [width-1:0] dout
);

    localparam int unsigned IW = width + CIC_GROWTH;

    logic signed [IW-1:0] comb_c     [CIC_N+1];
    logic signed [IW-1:0] comb_dly_q [CIC_N];
    logic signed [IW-1:0] comb_dly_d [CIC_N];
    logic signed [IW-1:0] comb_out_q;
    logic signed [IW-1:0] comb_out_d;
    logic signed [IW-1:0] integ_q    [CIC_N];
    logic signed [IW-1:0] integ_d    [CIC_N];
    logic signed [width-1:0] dout_q;
    logic signed [width-1:0] dout_d;

    // Comb chain, integrators and scale; all arithmetic wraps modulo 2^IW
    always_comb begin
        comb_c[0] = IW'(din);
        for (int s = 0; s < int'(CIC_N); s++) begin
            comb_c[s+1] = comb_c[s] - comb_dly_q[s];
        end

        comb_out_d = comb_out_q;
        for (int s = 0; s < int'(CIC_N); s++) begin
            comb_dly_d[s] = comb_dly_q[s];
        end
        if (in_strobe) begin
            comb_out_d = comb_c[CIC_N];
            for (int s = 0; s < int'(CIC_N); s++) begin
                comb_dly_d[s] = comb_c[s];
            end
        end

        // Zero-stuffing upsampler: comb output enters only in its slot
        integ_d[0] = integ_q[0] + (phase0 ? comb_out_q : '0);
        for (int s = 1; s < int'(CIC_N); s++) begin
            integ_d[s] = integ_q[s] + integ_q[s-1];
        end

        dout_d = width'(saturate(64'(integ_q[CIC_N-1] >>> CIC_SHIFT), width));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < int'(CIC_N); s++) begin
                comb_dly_q[s] <= '0;
                integ_q[s]    <= '0;
            end
            comb_out_q <= '0;
            dout_q     <= '0;
        end else begin
            for (int s = 0; s < int'(CIC_N); s++) begin
                comb_dly_q[s] <= comb_dly_d[s];
                integ_q[s]    <= integ_d[s];
            end
            comb_out_q <= comb_out_d;
            dout_q     <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/duc.sv
// Digital up-converter: baseband I/Q at fs/16 in, real fs/4 IF out.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   BaseBand_I/BaseBand_Q  - signed baseband samples, taken in the accept slot
//   bb_valid               - source has a sample; only looked at in the accept slot
//   bb_ready               - accept slot, one cycle in every 16
//   IF_Signal              - signed real IF sample, one per clock
//   underrun               - sticky: an accept slot found bb_valid low
module duc
    import duc_pkg::*;
#(
    parameter int unsigned width = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [width-1:0] BaseBand_I,
    input  logic signed [width-1:0] BaseBand_Q,
    input  logic                    bb_valid,
    output logic                    bb_ready,
    output logic signed [width-1:0] IF_Signal,
    output logic                    underrun
);

    localparam int unsigned PW = CIC_LOG2R;

    logic [PW-1:0]           phase_q, phase_d;
    logic                    ready_q, ready_d;
    logic                    strobe_q, strobe_d;
    logic                    slot_q, slot_d;
    logic                    underrun_q, underrun_d;
    logic signed [width-1:0] in_i_q, in_i_d;
    logic signed [width-1:0] in_q_q, in_q_d;
    logic [1:0]              mix_q, mix_d;
    logic signed [width-1:0] if_q, if_d;
    logic signed [width-1:0] env_i;
    logic signed [width-1:0] env_q;
    logic                    accept;

    // The registered ready flag marks the accept cycle
    assign accept = ready_q;

    // Phase counter, handshake capture, underrun flag and fs/4 mixer
    always_comb begin
        phase_d = phase_q + PW'(1);
        // Registered one cycle ahead so bb_ready is high while phase is 15
        ready_d = (phase_q == PW'(CIC_R - 2));

        // Missing sample is replaced by zero on both rails
        in_i_d = in_i_q;
        in_q_d = in_q_q;
        if (accept) begin
            in_i_d = bb_valid ? BaseBand_I : '0;
            in_q_d = bb_valid ? BaseBand_Q : '0;
        end
        underrun_d = underrun_q | (accept & ~bb_valid);

        // strobe loads the comb the cycle after capture; slot feeds the
        // integrators the cycle after that
        strobe_d = accept;
        slot_d   = strobe_q;

        // Mixer uses the incoming phase so IF_Signal lines up with mix_q
        mix_d = mix_q + 2'd1;
        if_d  = '0;
        unique case (mix_phase_e'(mix_d))
            MIX_I:  if_d = env_i;
            MIX_NQ: if_d = width'(saturate(-(64'(env_q)), width));
            MIX_NI: if_d = width'(saturate(-(64'(env_i)), width));
            MIX_Q:  if_d = env_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= '0;
            ready_q    <= 1'b0;
            strobe_q   <= 1'b0;
            slot_q     <= 1'b0;
            underrun_q <= 1'b0;
            in_i_q     <= '0;
            in_q_q     <= '0;
            mix_q      <= '0;
            if_q       <= '0;
        end else begin
            phase_q    <= phase_d;
            ready_q    <= ready_d;
            strobe_q   <= strobe_d;
            slot_q     <= slot_d;
            underrun_q <= underrun_d;
            in_i_q     <= in_i_d;
            in_q_q     <= in_q_d;
            mix_q      <= mix_d;
            if_q       <= if_d;
        end
    end

    cic_interp #(.width(width)) u_cic_i (
        .clk       (clk),
        .rst       (rst),
        .in_strobe (strobe_q),
        .phase0    (slot_q),
        .din       (in_i_q),
        .dout      (env_i)
    );

    cic_interp #(.width(width)) u_cic_q (
        .clk       (clk),
        .rst       (rst),
        .in_strobe (strobe_q),
        .phase0    (slot_q),
        .din       (in_q_q),
        .dout      (env_q)
    );

    assign bb_ready  = ready_q;
    assign IF_Signal = if_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_duc.sv
// Directed bench for the digital up-converter.
module tb_duc;

    localparam int unsigned W = 12;

    logic                clk;
    logic                rst;
    logic signed [W-1:0] bb_i;
    logic signed [W-1:0] bb_q;
    logic                bb_valid;
    logic                bb_ready;
    logic signed [W-1:0] if_sig;
    logic                underrun;

    int vectors;
    int errors;
    int k;              // clock edges since the last reset edge
    int acc_i[$];       // samples the DUT should have taken, one per accept
    int acc_q[$];
    logic exp_under;
    logic signed [W-1:0] cur_i;
    logic signed [W-1:0] cur_q;
    logic cur_v;
    logic junk;         // drive noise on the inputs outside accept slots
    int env [64];       // unmixed envelope rebuilt from the impulse runs

    initial clk = 1'b0;
    always #5 clk = ~clk;

    duc #(.width(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .BaseBand_I (bb_i),
        .BaseBand_Q (bb_q),
        .bb_valid   (bb_valid),
        .bb_ready   (bb_ready),
        .IF_Signal  (if_sig),
        .underrun   (underrun)
    );

    // Unit impulse response of a 3-stage R=16 interpolating CIC
    function automatic int h(int n);
        if (n < 0 || n > 45) return 0;
        if (n < 16) return (n + 1) * (n + 2) / 2;
        if (n < 32) return (n + 1) * (n + 2) / 2 - 3 * (n - 15) * (n - 14) / 2;
        return (46 - n) * (47 - n) / 2;
    endfunction

    function automatic int sat(int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    // Accept j lands on edge 16*(j+1); its envelope reaches IF six edges later
    function automatic int model_if(int kk);
        int ei;
        int eq;
        ei = 0;
        eq = 0;
        for (int j = 0; j < acc_i.size(); j++) begin
            ei += acc_i[j] * h(kk - 6 - 16 * (j + 1));
            eq += acc_q[j] * h(kk - 6 - 16 * (j + 1));
        end
        ei = sat(ei >>> 8);
        eq = sat(eq >>> 8);
        case (kk % 4)
            0:       return ei;
            1:       return sat(-eq);
            2:       return sat(-ei);
            default: return eq;
        endcase
    endfunction

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] want);
        vectors++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, got, want);
        end
    endtask

    task automatic check_cycle();
        check("ready", 32'(bb_ready), ((k % 16) == 15) ? 32'sd1 : 32'sd0);
        check("underrun", 32'(underrun), 32'(exp_under));
        check("if", 32'(if_sig), model_if(k));
    endtask

    // Drive inputs for the coming edge, take it, then check outputs
    task automatic tick();
        logic slot;
        slot = ((k + 1) % 16) == 0;
        if (slot) begin
            bb_valid = cur_v;
            bb_i     = cur_i;
            bb_q     = cur_q;
            acc_i.push_back(cur_v ? int'(cur_i) : 0);
            acc_q.push_back(cur_v ? int'(cur_q) : 0);
            if (!cur_v) exp_under = 1'b1;
        end else if (junk) begin
            bb_valid = 1'($urandom_range(0, 1));
            bb_i     = W'($urandom);
            bb_q     = W'($urandom);
        end else begin
            bb_valid = cur_v;
            bb_i     = cur_i;
            bb_q     = cur_q;
        end
        @(posedge clk);
        #1;
        k++;
        check_cycle();
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        bb_valid = 1'b1;
        bb_i     = W'(77);
        bb_q     = W'(-33);
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        k   = 0;
        acc_i.delete();
        acc_q.delete();
        exp_under = 1'b0;
        check("rst_if", 32'(if_sig), 32'sd0);
        check("rst_ready", 32'(bb_ready), 32'sd0);
        check("rst_underrun", 32'(underrun), 32'sd0);
    endtask

    // Constant input; after settling the IF must cycle through pattern p
    task automatic dc_run(input int nrst, input logic signed [W-1:0] ii,
                          input logic signed [W-1:0] qq, input logic jk,
                          input int p0, input int p1, input int p2, input int p3);
        int pat [4];
        pat = '{p0, p1, p2, p3};
        do_reset(nrst);
        junk  = jk;
        cur_v = 1'b1;
        cur_i = ii;
        cur_q = qq;
        repeat (120) tick();
        for (int t = 0; t < 8; t++) begin
            tick();
            check("dc_pattern", 32'(if_sig), 32'(pat[k % 4]));
        end
        junk = 1'b0;
    endtask

    // Single nonzero sample then zeros; record the demixed envelope
    task automatic impulse_run(input logic signed [W-1:0] ii,
                               input logic signed [W-1:0] qq, input logic odd);
        int n;
        do_reset(2);
        cur_v = 1'b1;
        cur_i = ii;
        cur_q = qq;
        while (k < 16) tick();
        cur_i = '0;
        cur_q = '0;
        while (k < 76) begin
            tick();
            if (k == 21) check("imp_before", 32'(if_sig), 32'sd0);
            if (k == 22 && !odd) check("imp_first_i", 32'(if_sig), -32'sd1);
            if (k == 23 && odd) check("imp_first_q", 32'(if_sig), 32'sd3);
            if (k >= 22) begin
                n = k - 22;
                case (k % 4)
                    0: if (!odd) env[n] = int'(if_sig);
                    1: if (odd) env[n] = -int'(if_sig);
                    2: if (!odd) env[n] = -int'(if_sig);
                    default: if (odd) env[n] = int'(if_sig);
                endcase
            end
        end
    endtask

    initial begin
        int area;
        vectors  = 0;
        errors   = 0;
        k        = 0;
        junk     = 1'b0;
        cur_v    = 1'b1;
        cur_i    = '0;
        cur_q    = '0;
        bb_valid = 1'b0;
        bb_i     = '0;
        bb_q     = '0;
        rst      = 1'b1;
        for (int n = 0; n < 64; n++) env[n] = 0;

        // Reset, ready cadence and DC on I with noise outside accept slots
        dc_run(3, 12'sd1000, 12'sd0, 1'b1, 1000, 0, -1000, 0);

        // DC on Q
        dc_run(2, 12'sd0, 12'sd500, 1'b0, 0, -500, 0, 500);

        // Impulse on each rail; together they give the whole envelope
        impulse_run(12'sd256, 12'sd0, 1'b0);
        impulse_run(12'sd0, 12'sd256, 1'b1);
        area = 0;
        for (int n = 0; n < 46; n++) area += env[n];
        check("imp_area", 32'(area), 32'sd4096);
        check("imp_peak", 32'(env[22]), 32'sd192);
        for (int n = 0; n < 23; n++) begin
            check("imp_symmetry", 32'(env[n]), 32'(env[45 - n]));
        end

        // Full-scale negative input: mixer negation must clamp
        dc_run(2, -12'sd2048, 12'sd0, 1'b0, -2048, 0, 2047, 0);

        // Underrun on the second accept, then reset mid-stream
        do_reset(2);
        cur_v = 1'b1;
        cur_i = 12'sd1000;
        cur_q = 12'sd0;
        while (k < 31) tick();
        check("under_before", 32'(underrun), 32'sd0);
        cur_v = 1'b0;
        tick();
        cur_v = 1'b1;
        check("under_set", 32'(underrun), 32'sd1);
        while (k < 70) tick();
        check("under_sticky", 32'(underrun), 32'sd1);
        dc_run(1, 12'sd1000, 12'sd0, 1'b0, 1000, 0, -1000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
